// File: rtl/z80_bus_master.sv
// Z80-style bus initiator: turns a req/done handshake into T-state timed memory and I/O cycles.
// Optional BUSREQ_n/BUSACK_n bus hand-over when compiled with `define Z80M_BUSREQ_EN.
module z80_bus_master #(
  parameter int TSTATE_CLKS = 4,
  parameter int ADDR_W      = 16,
  parameter int MAX_WAIT    = 255
) (
  input  logic              clk25,
  input  logic              RESET,
  input  logic              req,
  input  logic              req_io,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] A,
  output logic [7:0]        D_out,
  output logic              D_oe,
  input  logic [7:0]        D_in,
  output logic              MREQ_n,
  output logic              IORQ_n,
  output logic              RD_n,
  output logic              WR_n,
  input  logic              WAIT_n
`ifdef Z80M_BUSREQ_EN
  ,
  input  logic              BUSREQ_n,
  output logic              BUSACK_n
`endif
);

  localparam int PH_W   = (TSTATE_CLKS > 2) ? $clog2(TSTATE_CLKS) : 1;
  localparam int H      = TSTATE_CLKS / 2;
  localparam int WCNT_W = $clog2(MAX_WAIT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW, S_T3, S_BUSGRANT
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   ph;
  logic [WCNT_W-1:0] wcnt;
  logic              io_q;
  logic              we_q;
  logic              last_ph;
  logic              half_ph;

  assign last_ph = (ph == PH_W'(TSTATE_CLKS - 1));
  assign half_ph = (ph == PH_W'(H - 1));

  // Strobe edges are scheduled one clk early so every bus output comes straight from a flop.
  always_ff @(posedge clk25) begin
    if (RESET) begin
      // NOTE: reset is synchronous and covers the data path too, so A/D_out/rdata never show X.
      state  <= S_IDLE;
      ph     <= '0;
      wcnt   <= '0;
      io_q   <= 1'b0;
      we_q   <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      A      <= '0;
      D_out  <= '0;
      D_oe   <= 1'b0;
      MREQ_n <= 1'b1;
      IORQ_n <= 1'b1;
      RD_n   <= 1'b1;
      WR_n   <= 1'b1;
`ifdef Z80M_BUSREQ_EN
      BUSACK_n <= 1'b1;
`endif
    end else begin
      // NOTE: default-low each edge makes done/err single-clk pulses without extra clear logic.
      done <= 1'b0;
      err  <= 1'b0;
      ph   <= last_ph ? '0 : ph + 1'b1;
      case (state)
        S_IDLE: begin
          ph <= '0;
`ifdef Z80M_BUSREQ_EN
          if (!BUSREQ_n) begin
            state    <= S_BUSGRANT;
            BUSACK_n <= 1'b0;
            ready    <= 1'b0;
          end else
`endif
          if (req) begin
            state <= S_T1;
            io_q  <= req_io;
            we_q  <= req_we;
            A     <= req_addr;
            D_out <= req_wdata;
            D_oe  <= req_we;
            wcnt  <= '0;
            ready <= 1'b0;
          end
        end
        S_T1: begin
          if (half_ph && !io_q) begin
            MREQ_n <= 1'b0;
            RD_n   <= we_q;
          end
          if (last_ph) begin
            state <= S_T2;
            WR_n  <= !we_q;
            if (io_q) begin
              IORQ_n <= 1'b0;
              RD_n   <= we_q;
            end
          end
        end
        S_T2, S_TW: begin
          if (last_ph) begin
            if (state == S_T2 && io_q) begin
              state <= S_TW;  // automatic I/O wait state, not counted as extra
            end else if (WAIT_n) begin
              state <= S_T3;
              if (!we_q) rdata <= D_in;
            end else if (wcnt == WCNT_W'(MAX_WAIT)) begin
              state  <= S_IDLE;
              err    <= 1'b1;
              ready  <= 1'b1;
              D_oe   <= 1'b0;
              MREQ_n <= 1'b1;
              IORQ_n <= 1'b1;
              RD_n   <= 1'b1;
              WR_n   <= 1'b1;
            end else begin
              state <= S_TW;
              wcnt  <= wcnt + 1'b1;
            end
          end
        end
        S_T3: begin
          if (half_ph) begin
            MREQ_n <= 1'b1;
            IORQ_n <= 1'b1;
            RD_n   <= 1'b1;
            WR_n   <= 1'b1;
          end
          if (last_ph) begin
            done <= 1'b1;
            D_oe <= 1'b0;
`ifdef Z80M_BUSREQ_EN
            if (!BUSREQ_n) begin
              state    <= S_BUSGRANT;
              BUSACK_n <= 1'b0;
              ready    <= 1'b0;
            end else begin
              state <= S_IDLE;
              ready <= 1'b1;
            end
`else
            state <= S_IDLE;
            ready <= 1'b1;
`endif
          end
        end
`ifdef Z80M_BUSREQ_EN
        S_BUSGRANT: begin
          if (BUSREQ_n) begin
            state    <= S_IDLE;
            BUSACK_n <= 1'b1;
            ready    <= 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Randomised scoreboard bench for z80_bus_master: stimulus pushes expected cycles, a monitor
// measures strobe widths, cycle length and read data and pops/compares on done/err.
module tb_z80_bus_master;
  localparam int T    = 4;
  localparam int H    = T / 2;
  localparam int MAXW = 3;
  localparam int AW   = 16;

  logic          clk25 = 1'b0;
  logic          RESET = 1'b1;
  logic          req = 1'b0, req_io = 1'b0, req_we = 1'b0, WAIT_n = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_wdata = '0, D_in = '0;
  logic          ready, done, err, D_oe, MREQ_n, IORQ_n, RD_n, WR_n;
  logic [7:0]    rdata, D_out;
  logic [AW-1:0] A;
`ifdef Z80M_BUSREQ_EN
  logic          BUSREQ_n = 1'b1;
  logic          BUSACK_n;
`endif

  z80_bus_master #(.TSTATE_CLKS(T), .ADDR_W(AW), .MAX_WAIT(MAXW)) dut (
    .clk25(clk25), .RESET(RESET), .req(req), .req_io(req_io), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .MREQ_n(MREQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n), .WAIT_n(WAIT_n)
`ifdef Z80M_BUSREQ_EN
    , .BUSREQ_n(BUSREQ_n), .BUSACK_n(BUSACK_n)
`endif
  );

  always #5 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  typedef struct {
    bit            io, we, is_err;
    logic [AW-1:0] addr;
    logic [7:0]    wdata, din;
    int            accept_edge, dur, mreq, iorq, rd, wr, doe;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req_v);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Reference model: cycle length and low-strobe widths straight from T-state arithmetic.
  function automatic exp_t model(bit io, bit we, logic [AW-1:0] addr, logic [7:0] wdata,
                                 logic [7:0] din, int waits);
    exp_t e;
    e.io = io; e.we = we; e.addr = addr; e.wdata = wdata; e.din = din;
    e.accept_edge = 0;
    e.is_err = (waits > MAXW);
    e.mreq = 0; e.iorq = 0; e.rd = 0; e.wr = 0;
    if (e.is_err) begin
      e.dur = (io ? 3 : 2) * T + MAXW * T;
      if (io) begin
        e.iorq = e.dur - T;
        if (we) e.wr = e.dur - T; else e.rd = e.dur - T;
      end else begin
        e.mreq = e.dur - H;
        if (we) e.wr = e.dur - T; else e.rd = e.dur - H;
      end
    end else begin
      e.dur = (io ? 4 : 3) * T + waits * T;
      if (io) begin
        e.iorq = (2 + waits) * T + H;
        if (we) e.wr = e.iorq; else e.rd = e.iorq;
      end else begin
        e.mreq = (2 + waits) * T;
        if (we) e.wr = (1 + waits) * T + H; else e.rd = e.mreq;
      end
    end
    e.doe = we ? e.dur : 0;
    return e;
  endfunction

  int last_end  = 0;
  bit prev_keep = 1'b0;

  // Called aligned to a negedge; returns at the negedge where done/err is seen.
  task automatic run_txn(input bit io, input bit we, input logic [AW-1:0] addr,
                         input logic [7:0] wdata, input logic [7:0] din, input int waits,
                         input bit keep);
    exp_t e;
    int   n;
    e = model(io, we, addr, wdata, din, waits);
    req_io = io; req_we = we; req_addr = addr; req_wdata = wdata; D_in = din;
    WAIT_n = (waits == 0);
    req = 1'b1;
    n = 0;
    while (!ready && n < 500) begin
      @(negedge clk25);
      n++;
    end
    if (!ready) check(1'b0, "accept_timeout", 0, 1);
    @(posedge clk25);
    #1;
    e.accept_edge = cyc;
    q.push_back(e);
    if (prev_keep) check(cyc == last_end + 1, "b2b_accept_edge", cyc, last_end + 1);
    check(ready == 1'b0, "ready_low_in_cycle", ready, 0);
    req       = keep;
    req_io    = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = 8'($urandom);
    if (waits > 0) begin
      repeat ((io ? 3 : 2) * T + (waits - 1) * T) @(posedge clk25);
      #1 WAIT_n = 1'b1;
    end
    @(negedge clk25);
    n = 0;
    while (!(done || err) && n < 500) begin
      @(negedge clk25);
      n++;
    end
    if (!(done || err)) check(1'b0, "end_timeout", 0, 1);
    last_end  = cyc;
    prev_keep = keep;
  endtask

  task automatic check_reset(input string tag);
    check({ready, done, err, D_oe, MREQ_n, IORQ_n, RD_n, WR_n} == 8'b1000_1111,
          {tag, "_ctrl"}, {ready, done, err, D_oe, MREQ_n, IORQ_n, RD_n, WR_n}, 8'b1000_1111);
    check(A == '0, {tag, "_A"}, A, 0);
    check(D_out == 8'h00, {tag, "_D_out"}, D_out, 0);
    check(rdata == 8'h00, {tag, "_rdata"}, rdata, 0);
  endtask

  // Monitor: integrates bus activity per cycle and scores it when done/err appears.
  int         c_mreq = 0, c_iorq = 0, c_rd = 0, c_wr = 0, c_doe = 0, c_ovl = 0, c_bus = 0;
  int         gap = 0;
  bit         any_prev = 1'b0, seen_txn = 1'b0, any_low;
  logic [7:0] m_rdata = 8'h00;
  exp_t       me;

  always @(negedge clk25) begin
    if (RESET) begin
      c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_doe = 0; c_ovl = 0; c_bus = 0;
      gap = 0; any_prev = 1'b0; seen_txn = 1'b0; m_rdata = 8'h00;
    end else begin
      any_low = !(MREQ_n && IORQ_n && RD_n && WR_n);
      if (!MREQ_n) c_mreq++;
      if (!IORQ_n) c_iorq++;
      if (!RD_n)   c_rd++;
      if (!WR_n)   c_wr++;
      if (D_oe)    c_doe++;
      if ((!MREQ_n && !IORQ_n) || (!RD_n && !WR_n)) c_ovl++;
      if (any_low && q.size() > 0) begin
        if (A !== q[0].addr) c_bus++;
        if (!WR_n && D_out !== q[0].wdata) c_bus++;
      end
      if (any_low && !any_prev && seen_txn) check(gap >= H, "strobe_gap", gap, H);
      if (any_low) gap = 0; else gap++;
      any_prev = any_low;
      if (done || err) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_done_err", {done, err}, 0);
        end else begin
          me = q.pop_front();
          check(done != err, "done_xor_err", {done, err}, me.is_err ? 1 : 2);
          check(err == me.is_err, "end_kind_err", err, me.is_err);
          check(cyc - me.accept_edge == me.dur, "cycle_len", cyc - me.accept_edge, me.dur);
          check(c_mreq == me.mreq, "mreq_width", c_mreq, me.mreq);
          check(c_iorq == me.iorq, "iorq_width", c_iorq, me.iorq);
          check(c_rd == me.rd, "rd_width", c_rd, me.rd);
          check(c_wr == me.wr, "wr_width", c_wr, me.wr);
          check(c_doe == me.doe, "d_oe_width", c_doe, me.doe);
          check(c_ovl == 0, "strobe_overlap", c_ovl, 0);
          check(c_bus == 0, "addr_data_hold", c_bus, 0);
          if (done && !me.we) m_rdata = me.din;
          check(rdata == m_rdata, "rdata", rdata, m_rdata);
          if (err) check({MREQ_n, IORQ_n, RD_n, WR_n, D_oe} == 5'b11110, "abort_bus_idle",
                         {MREQ_n, IORQ_n, RD_n, WR_n, D_oe}, 5'b11110);
        end
        c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_doe = 0; c_ovl = 0; c_bus = 0;
        seen_txn = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, waits;
    bit kp;
    RESET = 1'b1;
    repeat (3) @(posedge clk25);
    @(negedge clk25);
    check_reset("reset");
    @(posedge clk25);
    #1 RESET = 1'b0;
    @(negedge clk25);

    run_txn(1'b1, 1'b1, 16'h0042, 8'hA5, 8'h00, 0, 1'b0);     // I/O write
    run_txn(1'b0, 1'b1, 16'h4000, 8'h3C, 8'h00, 0, 1'b0);     // memory write
    run_txn(1'b0, 1'b0, 16'h5800, 8'h00, 8'h7E, 0, 1'b0);     // memory read
    run_txn(1'b1, 1'b0, 16'h0013, 8'h00, 8'hC3, MAXW, 1'b0);  // I/O read, most waits allowed
    run_txn(1'b1, 1'b0, 16'h0014, 8'h00, 8'h99, MAXW + 1, 1'b0);
    run_txn(1'b0, 1'b1, 16'h1234, 8'h55, 8'h00, MAXW + 1, 1'b0);
    run_txn(1'b0, 1'b0, 16'h2000, 8'h00, 8'h81, 1, 1'b0);
    run_txn(1'b0, 1'b1, 16'h6000, 8'h11, 8'h00, 0, 1'b1);     // back-to-back chain
    run_txn(1'b1, 1'b1, 16'h0070, 8'h22, 8'h00, 0, 1'b1);
    run_txn(1'b0, 1'b0, 16'h6001, 8'h00, 8'h5A, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r     = $urandom_range(0, 9);
      waits = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, MAXW) : MAXW + 1;
      kp    = 1'($urandom_range(0, 1));
      run_txn(1'($urandom), 1'($urandom), AW'($urandom), 8'($urandom), 8'($urandom), waits, kp);
    end
    req = 1'b0;
    prev_keep = 1'b0;

    // Reset in the middle of an I/O write, during T2 ph=1.
    req_io = 1'b1; req_we = 1'b1; req_addr = 16'h00AB; req_wdata = 8'h5C; WAIT_n = 1'b1;
    req = 1'b1;
    @(posedge clk25);
    #1 req = 1'b0;
    repeat (T + 1) @(posedge clk25);
    #1;
    check(IORQ_n == 1'b0, "iorq_before_reset", IORQ_n, 0);
    check(D_oe == 1'b1, "d_oe_before_reset", D_oe, 1);
    RESET = 1'b1;
    @(posedge clk25);
    @(negedge clk25);
    check_reset("mid_reset");
    @(posedge clk25);
    #1 RESET = 1'b0;
    repeat (20) @(negedge clk25);

    run_txn(1'b0, 1'b0, 16'h3FFF, 8'h00, 8'hE7, 2, 1'b0);
    repeat (20) @(negedge clk25);
    check(q.size() == 0, "queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
